// File: rtl/trace_pkg.sv
// trace_pkg: shared FSM state encoding and trace entry sizing for mem_write_tracer
package trace_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, HALT = 2'd2} trace_state_t;
  // Entry packs {pc, addr, data, cycle} MSB to LSB
  function automatic int entry_w(int aw, int dw, int cw);
    return 2 * aw + dw + cw;
  endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: circular trace buffer with overwrite-when-full and a registered read port
module trace_fifo #(
  parameter int W = 128,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          rvalid,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          pop_ok,
  output logic          drop
);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign pop_ok = pop && !empty;
  // A push into a full buffer with no pop evicts the oldest entry
  assign drop = push && full && !pop_ok;
  always_ff @(posedge CLK)
    if (push) mem[wp] <= wdata;
  always_ff @(posedge CLK) begin
    if (RST) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      rvalid <= pop_ok;
      if (pop_ok) rdata <= mem[rp];
      if (clr) begin
        wp <= '0;
        rp <= '0;
        count <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop_ok || drop) rp <= rp + 1'b1;
        count <= count + (PW+1)'(push && !pop_ok && !full) - (PW+1)'(pop_ok && !push);
      end
    end
  end
endmodule

// File: rtl/mem_write_tracer.sv
// mem_write_tracer: snoops data-memory writes into a time-stamped circular trace buffer
// Optional address window filter enabled by defining TRACE_FILTER_EN.
module mem_write_tracer
  import trace_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] inst_mem_address_i,
  input  logic [ADDR_W-1:0] data_mem_address_i,
  input  logic [DATA_W-1:0] data_mem_in_data_i,
  input  logic              data_mem_WE_i,
  input  logic [ADDR_W-1:0] filter_lo_i,
  input  logic [ADDR_W-1:0] filter_hi_i,
  input  logic              arm_i,
  input  logic              stop_i,
  input  logic              wrap_mode_i,
  input  logic              rd_req_i,
  output logic              rd_valid_o,
  output logic [ADDR_W-1:0] rd_pc_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  rd_cycle_o,
  output logic [PW:0]       count_o,
  output logic              overflow_o,
  output logic [1:0]        state_o
);
  localparam int EW = entry_w(ADDR_W, DATA_W, CNT_W);
  trace_state_t state;
  logic [CNT_W-1:0] cyc;
  logic [EW-1:0] rdata;
  logic in_win, cap, push, clr, fills, full, empty, pop_ok, drop;
`ifdef TRACE_FILTER_EN
  assign in_win = data_mem_address_i >= filter_lo_i && data_mem_address_i <= filter_hi_i;
`else
  logic unused_filter;
  assign unused_filter = ^{filter_lo_i, filter_hi_i};
  assign in_win = 1'b1;
`endif
  assign cap = state == CAPTURE && data_mem_WE_i && in_win;
  // In halt mode a full buffer only accepts a write into a slot freed by a same-cycle pop
  assign push = cap && (wrap_mode_i || !full || pop_ok);
  assign clr = arm_i && !stop_i && state != CAPTURE;
  assign fills = !wrap_mode_i && cap && (full || (count_o == (PW+1)'(DEPTH - 1) && !pop_ok));
  trace_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .CLK(CLK),
    .RST(RST),
    .clr(clr),
    .push(push),
    .pop(rd_req_i),
    .wdata({inst_mem_address_i, data_mem_address_i, data_mem_in_data_i, cyc}),
    .rdata(rdata),
    .rvalid(rd_valid_o),
    .count(count_o),
    .full(full),
    .empty(empty),
    .pop_ok(pop_ok),
    .drop(drop)
  );
  assign {rd_pc_o, rd_addr_o, rd_data_o, rd_cycle_o} = rdata;
  assign state_o = state;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cyc <= '0;
      overflow_o <= 1'b0;
    end else begin
      cyc <= cyc + 1'b1;
      overflow_o <= clr ? 1'b0 : (overflow_o || drop);
      if (stop_i && state == CAPTURE) state <= HALT;
      else if (clr) state <= CAPTURE;
      else if (fills) state <= HALT;
    end
  end
endmodule

// File: tb/tb_mem_write_tracer.sv
// tb_mem_write_tracer: directed scoreboard bench for mem_write_tracer
module tb_mem_write_tracer;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] cyc;
  } ent_t;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [31:0] pc, addr, data, flo, fhi;
  logic we = 1'b0, arm = 1'b0, stop = 1'b0, wrap = 1'b0, rd = 1'b0;
  logic rd_valid, overflow;
  logic [31:0] rd_pc, rd_addr, rd_data, rd_cycle;
  logic [4:0] count;
  logic [1:0] state;
  int checks = 0, errors = 0;
  logic [31:0] tb_cyc = 0;
  int pc_ctr = 32'h1000;
  ent_t model[$];
  ent_t exp_q[$];
  bit cap_on = 0;
  bit exp_ovf = 0;
  int exp_state = 0;

  mem_write_tracer dut (
    .CLK(CLK), .RST(RST),
    .inst_mem_address_i(pc), .data_mem_address_i(addr), .data_mem_in_data_i(data),
    .data_mem_WE_i(we), .filter_lo_i(flo), .filter_hi_i(fhi),
    .arm_i(arm), .stop_i(stop), .wrap_mode_i(wrap), .rd_req_i(rd),
    .rd_valid_o(rd_valid), .rd_pc_o(rd_pc), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
    .rd_cycle_o(rd_cycle), .count_o(count), .overflow_o(overflow), .state_o(state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) tb_cyc <= RST ? 32'd0 : tb_cyc + 32'd1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
`ifdef TRACE_FILTER_EN
    return a >= flo && a <= fhi;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_status(input string tag);
    chk({tag, ".count"}, 64'(count), 64'(model.size()));
    chk({tag, ".state"}, 64'(state), 64'(exp_state));
    chk({tag, ".ovf"}, 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic check_read(input string tag);
    ent_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, 64'(rd_valid), 64'd1);
      chk({tag, ".pc"}, 64'(rd_pc), 64'(e.pc));
      chk({tag, ".addr"}, 64'(rd_addr), 64'(e.addr));
      chk({tag, ".data"}, 64'(rd_data), 64'(e.data));
      chk({tag, ".cyc"}, 64'(rd_cycle), 64'(e.cyc));
    end else
      chk({tag, ".valid0"}, 64'(rd_valid), 64'd0);
  endtask

  // Drives one write (optionally with a same-cycle read) and updates the model
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit with_rd, input string tag);
    ent_t e, x;
    we = 1'b1; addr = a; data = d; pc = pc_ctr; rd = with_rd;
    e = '{pc: pc_ctr, addr: a, data: d, cyc: tb_cyc};
    pc_ctr += 4;
    if (with_rd && model.size() > 0) exp_q.push_back(model.pop_front());
    if (cap_on && in_win(a)) begin
      if (model.size() == 16) begin
        if (wrap) begin
          x = model.pop_front();
          model.push_back(e);
          exp_ovf = 1;
        end else begin
          cap_on = 0;
          exp_state = 2;
        end
      end else begin
        model.push_back(e);
        if (!wrap && model.size() == 16) begin
          cap_on = 0;
          exp_state = 2;
        end
      end
    end
    @(negedge CLK);
    we = 1'b0; rd = 1'b0;
    if (with_rd) check_read(tag);
  endtask

  task automatic rd_one(input string tag);
    rd = 1'b1;
    if (model.size() > 0) exp_q.push_back(model.pop_front());
    @(negedge CLK);
    rd = 1'b0;
    check_read(tag);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    if (exp_state != 1) begin
      model.delete();
      exp_ovf = 0;
      cap_on = 1;
      exp_state = 1;
    end
    @(negedge CLK);
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    if (exp_state == 1) begin
      exp_state = 2;
      cap_on = 0;
    end
    @(negedge CLK);
    stop = 1'b0;
  endtask

  initial begin
    pc = 0; addr = 0; data = 0; flo = 32'h100; fhi = 32'h1FF;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    check_status("reset");
    chk("reset.valid", 64'(rd_valid), 64'd0);
    chk("reset.rd_addr", 64'(rd_addr), 64'd0);
    chk("reset.rd_cycle", 64'(rd_cycle), 64'd0);
    // Basic three-write capture and in-order readout
    do_arm();
    check_status("arm");
    wr(32'd4, 32'd1, 0, "w4");
    wr(32'd8, 32'd2, 0, "w8");
    wr(32'd12, 32'd3, 0, "w12");
    check_status("three");
    rd_one("r0");
    rd_one("r1");
    rd_one("r2");
    @(negedge CLK);
    chk("pulse", 64'(rd_valid), 64'd0);
    rd_one("rempty");
    // Halt mode fills and halts, keeping the first 16 writes
    do_stop();
    check_status("stop");
    do_arm();
    for (int i = 0; i < 20; i++) wr(32'(16 + 4 * i), 32'(100 + i), 0, "halt_w");
    check_status("halt_full");
    for (int i = 0; i < 16; i++) rd_one("halt_rd");
    rd_one("halt_empty");
    // arm and stop together in HALT: stop wins
    arm = 1'b1; stop = 1'b1;
    @(negedge CLK);
    arm = 1'b0; stop = 1'b0;
    check_status("armstop");
    // Wrap mode overwrites the oldest entries
    wrap = 1'b1;
    do_arm();
    for (int i = 0; i < 20; i++) wr(32'(32'h400 + 4 * i), 32'(200 + i), 0, "wrap_w");
    check_status("wrap_full");
    rd_one("wrap_rd5");
    check_status("wrap_after_rd");
    // Full in wrap mode with simultaneous write and read
    do_stop();
    do_arm();
    for (int i = 0; i < 16; i++) wr(32'(32'h800 + 4 * i), 32'(300 + i), 0, "fill_w");
    check_status("fill16");
    wr(32'h900, 32'd999, 1, "wr_rd");
    check_status("wr_rd");
    wr(32'h904, 32'd998, 1, "wr_rd2");
    check_status("wr_rd2");
    // Address window (all captured unless TRACE_FILTER_EN)
    do_stop();
    do_arm();
    wr(32'h0FC, 32'd1, 0, "f0fc");
    wr(32'h100, 32'd2, 0, "f100");
    wr(32'h1FF, 32'd3, 0, "f1ff");
    wr(32'h200, 32'd4, 0, "f200");
    check_status("filter");
    for (int i = 0; i < 5; i++) rd_one("filter_rd");
    // Reset mid-capture with a pending read
    wrap = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'(32'h40 * i), 32'(i), 0, "pre_rst");
    check_status("pre_rst");
    RST = 1'b1; rd = 1'b1;
    @(negedge CLK);
    RST = 1'b0; rd = 1'b0;
    model.delete(); exp_q.delete();
    cap_on = 0; exp_ovf = 0; exp_state = 0;
    check_status("midrst");
    chk("midrst.valid", 64'(rd_valid), 64'd0);
    do_arm();
    wr(32'h10, 32'h55, 0, "post_rst");
    rd_one("post_rst_rd");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_write_tracer.md
# mem_write_tracer

Synthesizable, parametrised data-memory write tracer that sits on the CPU data-memory bus beside the RAM. It snoops every write strobe, time-stamps it with a free-running cycle counter and the current PC, and stores entries in a circular trace buffer. A host or debug port drains the buffer later. It replaces simulation-only `$display` monitoring with hardware that also runs on the board.

## Interface
- `ADDR_W`, 32: width of data address and PC.
- `DATA_W`, 32: width of write data.
- `DEPTH`, 16: trace entries; power of two, at least 2.
- `CNT_W`, 32: cycle-stamp width.
- `CLK` in 1: single clock; all logic on rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `inst_mem_address_i` in ADDR_W: current PC, sampled with the write.
- `data_mem_address_i` in ADDR_W: data-memory address.
- `data_mem_in_data_i` in DATA_W: data being written.
- `data_mem_WE_i` in 1: write strobe; one capture per cycle it is high.
- `filter_lo_i`, `filter_hi_i` in ADDR_W: inclusive address window.
- `arm_i` in 1: start capture (pulse).
- `stop_i` in 1: stop capture (pulse).
- `wrap_mode_i` in 1: 1 overwrites the oldest entry when full; 0 halts when full.
- `rd_req_i` in 1: pop the oldest entry.
- `rd_valid_o` out 1: read data valid.
- `rd_pc_o` out ADDR_W, `rd_addr_o` out ADDR_W, `rd_data_o` out DATA_W, `rd_cycle_o` out CNT_W: popped entry.
- `count_o` out $clog2(DEPTH)+1: entries held.
- `overflow_o` out 1: sticky flag; set when an entry is lost.
- `state_o` out 2: FSM state.

## Operation
- FSM states: IDLE=0, CAPTURE=1, HALT=2.
  - IDLE → CAPTURE on `arm_i`. Arming clears `count_o`, the buffer pointers and `overflow_o`.
  - CAPTURE → HALT on `stop_i`.
  - CAPTURE → HALT when `wrap_mode_i`=0 and a push makes the buffer full.
  - HALT → CAPTURE on `arm_i`, with the same clears as above.
  - `arm_i` and `stop_i` in the same cycle: `stop_i` wins.
- Capture condition: state is CAPTURE, `data_mem_WE_i`=1, and the address is within the filter window (see Configuration).
- An entry holds {PC, address, data, cycle}. The cycle value is the counter value in the capture cycle.
- Cycle counter: free-running from reset; wraps modulo 2^CNT_W.
- Full in wrap mode: the oldest entry is dropped, the new one is stored, `count_o` stays DEPTH, and `overflow_o` is set.
- Full in halt mode: the filling write is stored. Any later write is not captured and does not set `overflow_o`.
- Reads are legal in every state.
  - `rd_req_i` while empty is ignored; `rd_valid_o` stays 0.
- Push and pop in the same cycle:
  - Not full: `count_o` is unchanged.
  - Full in wrap mode: the pop returns the oldest entry, the push fills the freed slot, and `overflow_o` is not set.
- Pointers are $clog2(DEPTH) bits and wrap naturally.

## Timing
- Capture: the entry is written at the rising edge of the capture cycle. `count_o` updates on that same edge.
- Read latency is 1 cycle: a `rd_req_i` sampled at edge N gives `rd_valid_o`=1 with the entry fields for the cycle after edge N.
  - `rd_valid_o` is a single-cycle pulse per pop.
  - Back-to-back requests give back-to-back entries.
- A write captured at edge N is readable by a `rd_req_i` sampled at edge N+1.
- Reset values:
  - State IDLE, counter 0, `count_o` 0, `overflow_o` 0, `rd_valid_o` 0.
  - All `rd_*` data outputs 0.
  - Buffer contents are don't-care.
- `RST` during capture or readout: all of the above applies at the next edge, and pending reads are discarded.

## Configuration
- `TRACE_FILTER_EN` defined: capture requires `filter_lo_i` ≤ `data_mem_address_i` ≤ `filter_hi_i`, compared unsigned.
  - If lo > hi, nothing is captured.
- Not defined: every write is captured. The filter ports remain but are ignored.

## Structure
- Package `trace_pkg` holds:
  - `trace_state_t` enum (IDLE, CAPTURE, HALT).
  - A parametrised-width `trace_entry_t` struct, or field-offset constants.
- Sub-module `trace_fifo` holds the circular buffer with push, pop, overwrite-when-full, count and registered read port. The top contains the FSM, the filter and the cycle counter.

## Test plan
- Reset, arm, then write to addresses 4, 8 and 12 with data 1, 2, 3 → `count_o`=3. Three reads return addresses 4, 8, 12 in order with strictly increasing cycle stamps.
- Halt mode, DEPTH=16, 20 writes → `count_o`=16, state HALT, `overflow_o`=0, entries are the first 16 writes.
- Wrap mode, 20 writes → `count_o`=16, `overflow_o`=1, the first read returns the 5th write.
- Full in wrap mode with a simultaneous write and `rd_req_i` → the read returns the oldest entry, `count_o` stays 16, `overflow_o` is not newly set.
- Build with `TRACE_FILTER_EN`, window 0x100–0x1FF, writes to 0x0FC, 0x100, 0x1FF and 0x200 → exactly 0x100 and 0x1FF are captured. Build without the macro → all 4 are captured.
- `RST` asserted mid-capture with `count_o`=5 → next cycle: IDLE, `count_o`=0, `rd_valid_o`=0, counter=0.
